// File: rtl/fold2_pkg.sv
// Shared definitions for the 2-folded IIR input path: default width, sequencer
// state encoding and the fold phase values also used by the core wrapper.
package fold2_pkg;

    localparam int N_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } seq_state_t;

    localparam logic SW_PH0 = 1'b0;
    localparam logic SW_PH1 = 1'b1;

endpackage

// File: rtl/fold2_input_sequencer_if.sv
// Valid/ready sample stream into the fold2 input sequencer.
interface fold2_input_sequencer_if
    import fold2_pkg::*;
#(
    parameter int N = N_DEF
);
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/fold2_sample_fifo.sv
// Small synchronous sample FIFO; no pass-through, so a push into an empty FIFO
// becomes poppable one edge later.
module fold2_sample_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [N-1:0]     push_data,
    input  logic             pop,
    output logic [N-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fold2_input_sequencer.sv
// Feeds the 2-folded IIR core: one sample per two-clock period (switch 0 then 1),
// with coefficient updates shadowed until a period boundary.
module fold2_input_sequencer
    import fold2_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    fold2_input_sequencer_if.slave  s,
    input  logic [N-1:0]            coef_a_in,
    input  logic [N-1:0]            coef_b_in,
    input  logic                    coef_load,
    input  logic                    run,
    output logic [N-1:0]            Xn,
    output logic [N-1:0]            a,
    output logic [N-1:0]            b,
    output logic                    switch,
    output logic                    period_start,
    output logic                    underrun,
    output logic [LVL_W-1:0]        fifo_level
);

    // state | meaning
    // IDLE  | not sequencing; Xn/a/b hold last values
    // PH0   | first cycle of a period (switch=0, period_start=1)
    // PH1   | second cycle of a period (switch=1)

    seq_state_t   state;
    seq_state_t   state_nxt;
    logic         boundary;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic [N-1:0] fifo_head;
    logic [N-1:0] shadow_a;
    logic [N-1:0] shadow_b;
    logic         pending;

    assign s.s_ready = !fifo_full && !rst;
    assign boundary  = (state_nxt == PH0);
    assign fifo_pop  = boundary && !fifo_empty;

    fold2_sample_fifo #(
        .N     (N),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s.s_valid && s.s_ready),
        .push_data (s.s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = run ? PH0 : IDLE;
            PH0:     state_nxt = PH1;
            PH1:     state_nxt = run ? PH0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign switch       = (state == PH1) ? SW_PH1 : SW_PH0;
    assign period_start = (state == PH0);

    // A load on a boundary edge re-arms pending so it lands one period later
    always_ff @(posedge clk) begin
        if (rst) begin
            Xn       <= '0;
            a        <= '0;
            b        <= '0;
            underrun <= 1'b0;
            shadow_a <= '0;
            shadow_b <= '0;
            pending  <= 1'b0;
        end else begin
            if (boundary) begin
                if (!fifo_empty) begin
                    Xn <= fifo_head;
                end else begin
                    Xn       <= '0;
                    underrun <= 1'b1;
                end
                if (pending) begin
                    a <= shadow_a;
                    b <= shadow_b;
                end
            end
            if (coef_load) begin
                shadow_a <= coef_a_in;
                shadow_b <= coef_b_in;
                pending  <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fold2_input_sequencer.sv
// Self-checking bench for fold2_input_sequencer: a cycle vector table plus a
// scoreboard-driven stream with a small behavioural model.
module tb_fold2_input_sequencer;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int LVL_W = 3;

    logic             clk;
    logic             rst;
    logic [N-1:0]     coef_a_in;
    logic [N-1:0]     coef_b_in;
    logic             coef_load;
    logic             run;
    logic [N-1:0]     Xn;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             switch;
    logic             period_start;
    logic             underrun;
    logic [LVL_W-1:0] fifo_level;

    fold2_input_sequencer_if #(.N(N)) sif ();

    fold2_input_sequencer #(
        .N     (N),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (sif),
        .coef_a_in    (coef_a_in),
        .coef_b_in    (coef_b_in),
        .coef_load    (coef_load),
        .run          (run),
        .Xn           (Xn),
        .a            (a),
        .b            (b),
        .switch       (switch),
        .period_start (period_start),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic             rst;
        logic             v;
        logic [N-1:0]     d;
        logic             run;
        logic             cl;
        logic [N-1:0]     ca;
        logic [N-1:0]     cb;
        logic [N-1:0]     xn;
        logic [N-1:0]     ea;
        logic [N-1:0]     eb;
        logic             sw;
        logic             ps;
        logic             un;
        logic [LVL_W-1:0] lvl;
        logic             rdy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [N-1:0] d,
                                input logic rn, input logic cl, input logic [N-1:0] ca,
                                input logic [N-1:0] cb, input logic [N-1:0] xn,
                                input logic [N-1:0] ea, input logic [N-1:0] eb,
                                input logic sw, input logic ps, input logic un,
                                input logic [LVL_W-1:0] lvl, input logic rdy);
        vec_t t;
        t.rst = r;  t.v = v;   t.d = d;   t.run = rn; t.cl = cl; t.ca = ca; t.cb = cb;
        t.xn = xn;  t.ea = ea; t.eb = eb; t.sw = sw;  t.ps = ps; t.un = un;
        t.lvl = lvl; t.rdy = rdy;
        return t;
    endfunction

    vec_t tbl [24];

    // scoreboard model state
    logic [N-1:0] sbq [$];
    int           m_lvl;
    int           m_st;     // 0 idle, 1 first phase, 2 second phase
    logic [N-1:0] m_xn;
    logic         m_un;

    task automatic do_reset();
        rst         = 1'b1;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        run         = 1'b0;
        coef_load   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        m_lvl = 0;
        m_st  = 0;
        m_xn  = '0;
        m_un  = 1'b0;
    endtask

    task automatic sb_step(input logic v, input logic [N-1:0] d, input logic r);
        logic acc;
        int   nxt;
        sif.s_valid = v;
        sif.s_data  = d;
        run         = r;
        acc = v && (m_lvl < DEPTH);
        if (m_st == 1) nxt = 2;
        else           nxt = r ? 1 : 0;
        @(posedge clk);
        #1;
        if (nxt == 1) begin
            if (sbq.size() > 0) begin
                m_xn = sbq.pop_front();
                m_lvl--;
            end else begin
                m_xn = '0;
                m_un = 1'b1;
            end
        end
        if (acc) begin
            sbq.push_back(d);
            m_lvl++;
        end
        m_st = nxt;
        chk("sb_period_start", 32'(period_start), 32'(m_st == 1));
        chk("sb_switch", 32'(switch), 32'(m_st == 2));
        chk("sb_xn", 32'(Xn), 32'(m_xn));
        chk("sb_underrun", 32'(underrun), 32'(m_un));
        chk("sb_level", 32'(fifo_level), 32'(m_lvl));
        chk("sb_ready", 32'(sif.s_ready), 32'(m_lvl < DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst v  d      run cl ca     cb     xn     a      b      sw ps un lvl rdy
        tbl[0]  = mk(1, 1, 16'h55, 0,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 16'h55, 0,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 16'h0,  0,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 16'h0,  0,  1, 16'h2, 16'h7, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 1, 16'h5,  0,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 1);
        tbl[5]  = mk(0, 1, 16'h6,  1,  0, 16'h0, 16'h0, 16'h5, 16'h2, 16'h7, 0, 1, 0, 1, 1);
        tbl[6]  = mk(0, 1, 16'h7,  1,  0, 16'h0, 16'h0, 16'h5, 16'h2, 16'h7, 1, 0, 0, 2, 1);
        tbl[7]  = mk(0, 0, 16'h0,  1,  1, 16'h3, 16'h4, 16'h6, 16'h2, 16'h7, 0, 1, 0, 1, 1);
        tbl[8]  = mk(0, 0, 16'h0,  1,  0, 16'h0, 16'h0, 16'h6, 16'h2, 16'h7, 1, 0, 0, 1, 1);
        tbl[9]  = mk(0, 0, 16'h0,  1,  0, 16'h0, 16'h0, 16'h7, 16'h3, 16'h4, 0, 1, 0, 0, 1);
        tbl[10] = mk(0, 0, 16'h0,  1,  1, 16'h8, 16'h9, 16'h7, 16'h3, 16'h4, 1, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 16'h0,  1,  0, 16'h0, 16'h0, 16'h0, 16'h8, 16'h9, 0, 1, 1, 0, 1);
        tbl[12] = mk(0, 0, 16'h0,  0,  0, 16'h0, 16'h0, 16'h0, 16'h8, 16'h9, 1, 0, 1, 0, 1);
        tbl[13] = mk(0, 1, 16'h9,  0,  0, 16'h0, 16'h0, 16'h0, 16'h8, 16'h9, 0, 0, 1, 1, 1);
        tbl[14] = mk(0, 0, 16'h0,  1,  0, 16'h0, 16'h0, 16'h9, 16'h8, 16'h9, 0, 1, 1, 0, 1);
        tbl[15] = mk(0, 0, 16'h0,  0,  0, 16'h0, 16'h0, 16'h9, 16'h8, 16'h9, 1, 0, 1, 0, 1);
        tbl[16] = mk(0, 0, 16'h0,  0,  0, 16'h0, 16'h0, 16'h9, 16'h8, 16'h9, 0, 0, 1, 0, 1);
        tbl[17] = mk(0, 0, 16'h0,  1,  0, 16'h0, 16'h0, 16'h0, 16'h8, 16'h9, 0, 1, 1, 0, 1);
        tbl[18] = mk(0, 1, 16'h11, 1,  0, 16'h0, 16'h0, 16'h0, 16'h8, 16'h9, 1, 0, 1, 1, 1);
        tbl[19] = mk(1, 0, 16'h0,  1,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 16'h0,  0,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 1);
        tbl[21] = mk(0, 0, 16'h0,  1,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 0, 1);
        tbl[22] = mk(0, 0, 16'h0,  0,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0, 1, 0, 1);
        tbl[23] = mk(0, 0, 16'h0,  0,  0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 1);

        rst = 1'b1; sif.s_valid = 1'b0; sif.s_data = '0;
        run = 1'b0; coef_load = 1'b0; coef_a_in = '0; coef_b_in = '0;
        #1;

        for (int i = 0; i < 24; i++) begin
            rst         = tbl[i].rst;
            sif.s_valid = tbl[i].v;
            sif.s_data  = tbl[i].d;
            run         = tbl[i].run;
            coef_load   = tbl[i].cl;
            coef_a_in   = tbl[i].ca;
            coef_b_in   = tbl[i].cb;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_xn", i), 32'(Xn), 32'(tbl[i].xn));
            chk($sformatf("v%0d_a", i), 32'(a), 32'(tbl[i].ea));
            chk($sformatf("v%0d_b", i), 32'(b), 32'(tbl[i].eb));
            chk($sformatf("v%0d_switch", i), 32'(switch), 32'(tbl[i].sw));
            chk($sformatf("v%0d_period_start", i), 32'(period_start), 32'(tbl[i].ps));
            chk($sformatf("v%0d_underrun", i), 32'(underrun), 32'(tbl[i].un));
            chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_ready", i), 32'(sif.s_ready), 32'(tbl[i].rdy));
        end
        coef_load = 1'b0;

        // full FIFO: fill with run low, refuse a fifth sample, then drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            sb_step(1'b1, N'(16'hA1 + i), 1'b0);
        end
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        chk("full_ready", 32'(sif.s_ready), 32'd0);
        sb_step(1'b1, 16'hEE, 1'b0);
        chk("full_reject_level", 32'(fifo_level), 32'(DEPTH));
        sb_step(1'b1, 16'hEE, 1'b1);
        chk("full_first_pop_xn", 32'(Xn), 32'hA1);
        chk("full_ready_after_pop", 32'(sif.s_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            sb_step(1'b0, '0, 1'b1);
        end
        chk("full_drain_underrun", 32'(underrun), 32'd1);

        // random stream with run high, then let it drop
        do_reset();
        for (int i = 0; i < 120; i++) begin
            sb_step($urandom_range(0, 2) != 0, N'($urandom), 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            sb_step($urandom_range(0, 3) == 0, N'($urandom), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            sb_step(1'b1, N'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fold2_input_sequencer.md
Name: fold2_input_sequencer

Overview:
Upstream feeder for the 2-folded IIR core (Y[n] = a*Y[n-3] + b*Y[n-5] + X[n]). It accepts input samples over a valid/ready stream and buffers them in a small FIFO. It drives the core's Xn, a, b and switch inputs so that each sample period is exactly two clocks, with switch=0 then switch=1. Coefficient updates are shadowed and applied only on sample-period boundaries, so a and b never change mid-period.

Parameters:
N, 16, sample and coefficient width in bits
DEPTH, 4, sample FIFO depth in entries; power of 2, at least 2
LVL_W, 3, width of fifo_level; equals log2(DEPTH)+1

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
s_data  in  N  input sample
s_valid  in  1  s_data is valid
s_ready  out  1  sequencer can accept a sample
coef_a_in  in  N  new coefficient a
coef_b_in  in  N  new coefficient b
coef_load  in  1  one-cycle strobe; captures coef_a_in and coef_b_in into the shadow registers
run  in  1  enables sample-period sequencing
Xn  out  N  sample to the core; held for both cycles of a period
a  out  N  coefficient a to the core
b  out  N  coefficient b to the core
switch  out  1  fold phase: 0 in the first cycle of a period, 1 in the second
period_start  out  1  high in the first cycle of each period (switch=0 cycle while running)
underrun  out  1  sticky flag; set when a period starts with an empty FIFO
fifo_level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; FIFO emptied (level 0).
  - Xn, a, b, switch, period_start, underrun all become 0.
  - Shadow registers and the pending flag are cleared.
  - s_ready is forced to 0 while rst is high.
  - Reset takes effect mid-period with no completion of the current period.
- s_ready = !full && !rst. Push happens when s_valid && s_ready.
  - No pass-through: a push into an empty FIFO is not poppable in the same cycle.
  - When full, a simultaneous pop does not allow a same-cycle push.
- FSM states: IDLE, PH0, PH1. Outputs are registered from the state.
  - IDLE: switch=0, period_start=0; Xn, a and b hold their last values. Goes to PH0 when run=1.
  - PH0: switch=0, period_start=1. Always goes to PH1 on the next edge.
  - PH1: switch=1. Goes to PH0 if run=1, otherwise to IDLE. A period already begun always completes.
- On every edge whose next state is PH0 (period boundary):
  - FIFO non-empty: pop the head into Xn.
  - FIFO empty: Xn loads 0 and underrun is set.
  - Pending coefficient update: a and b load the shadow values and pending clears.
- coef_load:
  - Writes the shadow registers and sets pending.
  - A later load before the boundary overwrites the shadow; last write wins.
  - A load on the same edge as a boundary is not applied at that boundary; it is applied at the following one.
- underrun clears only on rst.
- Latency: a sample pushed at edge t into an empty FIFO appears on Xn at the first period boundary strictly after t. Minimum is 1 cycle, maximum 2 cycles while running.
- Steady-state throughput is 1 sample per 2 clocks. fifo_level counts from 0 to DEPTH; pointers wrap modulo DEPTH.
- All arithmetic is unsigned pointer/count arithmetic. Data is passed through untouched; the core interprets it as signed.

Decomposition:
- Shared package fold2_pkg:
  - N default
  - the state encoding (IDLE, PH0, PH1)
  - the phase constants SW_PH0=0 and SW_PH1=1, shared with the core wrapper
- One sub-module, fold2_sample_fifo: synchronous FIFO with DEPTH and N parameters, push/pop, full/empty and level, same clk/rst.
- The FSM, shadow coefficients and output registers stay in the top level.

Test Plan:
- Reset then idle: assert rst for 2 cycles with s_valid=1 → s_ready=0 during reset. Afterwards Xn=a=b=0, switch=0, fifo_level=0, underrun=0, s_ready=1.
- Steady stream: push 5,6,7 back-to-back, run=1 from the cycle after the first push → switch toggles 0,1,0,1,… and Xn holds 5, 6, 7 for two cycles each. period_start pulses every 2 cycles; underrun stays 0 until the FIFO drains.
- Full FIFO: with run=0, push DEPTH=4 samples → fifo_level=4 and s_ready=0. A fifth s_valid is not accepted. Set run=1 → the first pop frees space and s_ready returns to 1 the next cycle.
- Underrun: run=1 with an empty FIFO → Xn=0 at the first boundary and underrun=1. Then push 9 → Xn=9 at a later boundary while underrun stays 1.
- Coefficient shadowing: a=0x0002 is active. Pulse coef_load with a=0x0003, b=0x0004 while in PH0 → a/b stay unchanged through PH1 and switch to 3/4 at the next PH0. A load on the boundary edge is applied one period later.
- Run drop and mid-period reset: deassert run in PH0 → PH1 completes, then IDLE with switch=0 and Xn held. Assert rst in PH1 → next cycle IDLE with all outputs 0 and FIFO emptied.
